dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Sequencing FSM for the 2-way set-associative data cache: 32 sets, `WORDS`-word lines, one LRU bit per set.
- Accepts one CPU request at a time and runs the tag lookup.
- On a miss, writes back a dirty victim and refills the line from memory over a ready handshake.
- On completion, pulses `req_done`/`hit0` to the per-set LRU memory and `cpu_ready` to the CPU.
- Sits between the CPU port, the tag/data arrays (combinational read) and the memory bus.

Parameters:
- WORDS, 4: words per line; power of two, >= 2.
- OFF_W (localparam), $clog2(WORDS): word-offset width.
- TAG_W (localparam), 32-5-OFF_W-2: tag width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; fields {tag, idx[4:0], word[OFF_W-1:0], 2'b00}
- cpu_ready  out  1  one-cycle done pulse
- idx  out  5  latched set index driven to arrays and LRU memory
- tag  out  TAG_W  latched request tag driven to tag arrays
- tag_hit0, tag_hit1  in  1 each  way compare results for idx/tag
- victim_valid, victim_dirty  in  1 each  state of the way selected by lru1
- victim_tag  in  TAG_W  tag stored in the victim way
- lru1  in  1  from LRU memory; 1 = way1 is LRU
- arr_way  out  1  way addressed in data/tag arrays
- arr_word  out  OFF_W  word addressed in data array
- data_fill_we  out  1  write mem_rdata into data array at arr_way/arr_word
- tag_we  out  1  write {tag, valid=1, dirty=0} into arr_way at idx
- dirty_set  out  1  set dirty bit of arr_way at idx
- req_done  out  1  LRU memory update strobe
- hit0  out  1  1 = way0 was used (way1 becomes LRU)
- mem_req  out  1  memory request, held until the line transfer ends
- mem_we  out  1  1 = writeback, 0 = refill
- mem_addr  out  32  word address of the current beat
- mem_ready  in  1  beat accepted/returned this cycle

Behaviour:
- Reset: state = IDLE; counter = 0; all outputs 0 (idx, tag, arr_way, arr_word, mem_addr = 0). Reset mid-transfer aborts at once: mem_req is low on the first cycle after rst is sampled, and no partial tag_we is issued.
- States: IDLE, LOOKUP, WB, REFILL, DONE. Output strobes are registered; each is active exactly for one clock in the states listed.
- IDLE: on cpu_req = 1, latch cpu_addr fields and cpu_we, then go to LOOKUP. cpu_req in any other state is ignored; the requester holds until cpu_ready.
- LOOKUP: one cycle.
  - Hit: if tag_hit0 | tag_hit1, set arr_way = hit way and go to DONE. If both hits are set, way0 wins.
  - Miss: set arr_way = lru1.
    - victim_valid & victim_dirty: go to WB.
    - Otherwise: go to REFILL.
  - Counter cleared to 0.
- WB: mem_req = 1, mem_we = 1, mem_addr = {victim_tag, idx, counter, 2'b00}, arr_word = counter.
  - Each cycle with mem_ready = 1 advances the counter.
  - mem_ready on counter = WORDS-1 goes to REFILL with the counter wrapped to 0.
- REFILL: mem_req = 1, mem_we = 0, mem_addr = {tag, idx, counter, 2'b00}.
  - data_fill_we = mem_ready, arr_word = counter.
  - On the last beat, assert tag_we in the same cycle and go to DONE.
- DONE: one cycle.
  - req_done = 1, hit0 = ~arr_way, cpu_ready = 1, dirty_set = latched we; then IDLE.
- mem_ready outside WB/REFILL is ignored. mem_ready held high gives one beat per cycle.
- Latency from IDLE accept:
  - hit: 3 cycles (IDLE, LOOKUP, DONE).
  - clean miss: 3 + WORDS cycles at zero wait.
  - dirty miss: 3 + 2*WORDS cycles.
- Back-to-back: the cycle after DONE is IDLE, so a new request is accepted 1 cycle after cpu_ready.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs hit_cnt, miss_cnt, wb_cnt (32 bits each, wrapping, cleared by rst).
  - hit_cnt and miss_cnt increment on the LOOKUP outcome.
  - wb_cnt increments on WB entry.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then load hit: cpu_addr 0x0000_0104 (WORDS = 4), tag_hit1 = 1.
  - Required: cpu_ready on cycle 3; req_done = 1, hit0 = 0; idx = 16; no mem_req.
- Clean miss: lru1 = 0, victim_valid = 0, mem_ready held 1.
  - Required: 4 REFILL beats with mem_addr 0x..100, 104, 108, 10C; data_fill_we on each beat.
  - Required: tag_we on the 4th beat, then DONE with hit0 = 1.
- Dirty miss store: lru1 = 1, victim_dirty = 1, victim_tag = 0x3.
  - Required: 4 WB beats to {0x3, idx, w, 00} with mem_we = 1, then 4 refill beats.
  - Required: DONE with dirty_set = 1, hit0 = 0.
- Wait states: mem_ready low for 2 cycles between refill beats.
  - Required: counter, mem_addr and mem_req hold; no data_fill_we while mem_ready = 0.
- Reset asserted during the 2nd WB beat.
  - Required: next cycle state IDLE, mem_req = 0, tag_we never pulsed.
  - Required: a following request behaves as from reset.
- Both tag_hit0 and tag_hit1 = 1: required arr_way = 0, hit0 = 1. With DCACHE_STATS_EN, hit_cnt = 1 after this request.

Source files
------------

// File: rtl/dcache_if.sv
// dcache_if: bundles the CPU port, tag/data array port and memory bus of the data cache controller.
// Ports (slave = controller view):
//   cpu:    cpu_req, cpu_we, cpu_addr (in); cpu_ready (out)
//   arrays: tag_hit0/1, victim_valid/dirty/tag, lru1 (in); idx, tag, arr_way, arr_word,
//           data_fill_we, tag_we, dirty_set, req_done, hit0 (out)
//   memory: mem_ready (in); mem_req, mem_we, mem_addr (out)
interface dcache_if #(parameter int WORDS = 4);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 32 - 5 - OFF_W - 2;
  logic             cpu_req, cpu_we, cpu_ready;
  logic [31:0]      cpu_addr;
  logic [4:0]       idx;
  logic [TAG_W-1:0] tag, victim_tag;
  logic             tag_hit0, tag_hit1, victim_valid, victim_dirty, lru1;
  logic             arr_way, data_fill_we, tag_we, dirty_set, req_done, hit0;
  logic [OFF_W-1:0] arr_word;
  logic             mem_req, mem_we, mem_ready;
  logic [31:0]      mem_addr;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, tag_hit0, tag_hit1, victim_valid, victim_dirty,
           victim_tag, lru1, mem_ready,
    output cpu_ready, idx, tag, arr_way, arr_word, data_fill_we, tag_we, dirty_set,
           req_done, hit0, mem_req, mem_we, mem_addr
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, tag_hit0, tag_hit1, victim_valid, victim_dirty,
           victim_tag, lru1, mem_ready,
    input  cpu_ready, idx, tag, arr_way, arr_word, data_fill_we, tag_we, dirty_set,
           req_done, hit0, mem_req, mem_we, mem_addr
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: sequencing FSM for a 2-way set-associative data cache (32 sets, WORDS-word lines).
// Ports: clk, rst (sync, active high); bus (dcache_if.slave) carries CPU, array and memory signals.
// Optional: define DCACHE_STATS_EN to add hit_cnt, miss_cnt, wb_cnt (32-bit wrapping counters).
module dcache_ctrl #(parameter int WORDS = 4) (
  input  logic        clk,
  input  logic        rst,
`ifdef DCACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt,
`endif
  dcache_if.slave     bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 32 - 5 - OFF_W - 2;
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, WB = 3'd2, REFILL = 3'd3, DONE = 3'd4;
  logic [2:0]       state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             way_q, way_d, we_q, we_d;
  logic             hit, last, in_wb, in_refill, done, unused_addr;
  assign hit         = bus.tag_hit0 | bus.tag_hit1;
  assign last        = cnt_q == OFF_W'(WORDS - 1);
  assign in_wb       = state_q == WB;
  assign in_refill   = state_q == REFILL;
  assign done        = state_q == DONE;
  assign unused_addr = ^bus.cpu_addr[1+OFF_W:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    way_d   = way_q;
    we_d    = we_q;
    case (state_q)
      IDLE: if (bus.cpu_req) begin
        state_d = LOOKUP;
        idx_d   = bus.cpu_addr[6+OFF_W:2+OFF_W];
        tag_d   = bus.cpu_addr[31:7+OFF_W];
        we_d    = bus.cpu_we;
      end
      LOOKUP: begin
        cnt_d   = '0;
        // on a double hit way0 wins; on a miss the LRU way is the victim
        way_d   = hit ? ~bus.tag_hit0 : bus.lru1;
        state_d = hit ? DONE : (bus.victim_valid & bus.victim_dirty) ? WB : REFILL;
      end
      WB, REFILL: if (bus.mem_ready) begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = in_wb ? REFILL : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      way_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
      we_q    <= we_d;
    end
  end
  assign bus.idx          = idx_q;
  assign bus.tag          = tag_q;
  assign bus.arr_way      = way_q;
  assign bus.arr_word     = cnt_q;
  assign bus.cpu_ready    = done;
  assign bus.req_done     = done;
  assign bus.hit0         = done & ~way_q;
  assign bus.dirty_set    = done & we_q;
  assign bus.mem_req      = in_wb | in_refill;
  assign bus.mem_we       = in_wb;
  assign bus.mem_addr     = in_wb     ? {bus.victim_tag, idx_q, cnt_q, 2'b00} :
                            in_refill ? {tag_q, idx_q, cnt_q, 2'b00} : 32'd0;
  // array writes are suppressed in a reset cycle so an aborted refill never commits
  assign bus.data_fill_we = in_refill & bus.mem_ready & ~rst;
  assign bus.tag_we       = in_refill & bus.mem_ready & last & ~rst;
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state_q == LOOKUP) begin
        hit_cnt  <= hit_cnt + {31'd0, hit};
        miss_cnt <= miss_cnt + {31'd0, ~hit};
      end
      if (state_q == LOOKUP && state_d == WB) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif
endmodule
